// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: shares one external memory bus between the instruction
// fetch port and the data (load/store) port. One requester is granted at a
// time; the bus command is registered and held until bus_ready_in, and the
// granted requester then receives a one-cycle ready pulse with the read data
// passed straight through from the bus.
//
// Handshake: a requester raises its request and holds address/strobes/data
// stable until it sees its *_ready_out pulse. The bus side holds bus_* stable
// from the grant edge until the cycle bus_ready_in=1, which completes the
// transaction. A requester that drops or changes its request before completion
// gets no ready pulse; the bus transaction still finishes and its result is
// discarded.
module rv32_bus_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic [1:0]  dbg_state_out
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_INSTR_BUSY = 2'd1;
  localparam logic [1:0] ST_DATA_BUSY  = 2'd2;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_BURST);

  logic [1:0]  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wval_q, wval_d;

  logic data_req;
  logic grant_i;
  logic grant_d;
  logic data_kind_match;

  // Arbitration, command capture, completion and streak bookkeeping.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    mask_d   = mask_q;
    wval_d   = wval_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    data_req = data_read_in | data_write_in;

    case (state_q)
      ST_IDLE: begin
        // A pending fetch that has waited through a full data streak wins;
        // otherwise data has priority over fetch.
        if (instr_read_in && (streak_q == MAX_STREAK)) begin
          grant_i = 1'b1;
        end else if (data_req) begin
          grant_d = 1'b1;
        end else if (instr_read_in) begin
          grant_i = 1'b1;
        end

        if (!instr_read_in) begin
          streak_d = 4'd0;
        end

        if (grant_i) begin
          state_d  = ST_INSTR_BUSY;
          addr_d   = instr_address_in;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          mask_d   = 4'd0;
          wval_d   = 32'd0;
          streak_d = 4'd0;
        end else if (grant_d) begin
          state_d = ST_DATA_BUSY;
          addr_d  = data_address_in;
          // Write takes precedence so the two strobes can never both be set.
          rd_d    = data_read_in & ~data_write_in;
          wr_d    = data_write_in;
          mask_d  = data_write_in ? data_write_mask_in : 4'd0;
          wval_d  = data_write_value_in;
          if (instr_read_in && (streak_q < MAX_STREAK)) begin
            streak_d = 4'(streak_q + 4'd1);
          end
        end
      end

      ST_INSTR_BUSY, ST_DATA_BUSY: begin
        // Address and write value stay put; only the strobes and byte
        // enables drop. Always pass through IDLE before the next grant.
        if (bus_ready_in) begin
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          mask_d  = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        mask_d  = 4'd0;
      end
    endcase
  end

  // State and registered bus command; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      streak_q <= 4'd0;
      addr_q   <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mask_q   <= 4'd0;
      wval_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      mask_q   <= mask_d;
      wval_q   <= wval_d;
    end
  end

  // While busy, addr_q and wr_q hold the granted address and kind, so they
  // double as the latch for the "still the same request" check.
  always_comb begin
    data_kind_match = wr_q ? data_write_in : data_read_in;
    instr_ready_out = (state_q == ST_INSTR_BUSY) && bus_ready_in &&
                      instr_read_in && (instr_address_in == addr_q);
    data_ready_out  = (state_q == ST_DATA_BUSY) && bus_ready_in &&
                      data_kind_match && (data_address_in == addr_q);
  end

  assign instr_read_value_out = bus_read_value_in;
  assign data_read_value_out  = bus_read_value_in;
  assign bus_address_out      = addr_q;
  assign bus_read_out         = rd_q;
  assign bus_write_out        = wr_q;
  assign bus_write_mask_out   = mask_q;
  assign bus_write_value_out  = wval_q;
  assign dbg_state_out        = state_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: a vector table of fetch/load/store requests,
// a wait-state bus responder, a monitor that checks every bus command and
// ready pulse against expectation queues, and hand-written sequences for
// reset, anti-starvation, fetch redirect and mid-transaction reset.
module tb_rv32_bus_arbiter;

  localparam int unsigned MAX_BURST = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wval;
  } cmd_t;

  typedef struct {
    logic        use_i;
    logic [31:0] iaddr;
    logic        use_d;
    logic        d_wr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          waits;
    logic [3:0]  exp_mask;
    logic        data_first;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic [1:0]  dbg_state_out;

  always #5 clk = ~clk;

  rv32_bus_arbiter #(.MAX_DATA_BURST(MAX_BURST)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .bus_address_out      (bus_address_out),
    .bus_read_out         (bus_read_out),
    .bus_write_out        (bus_write_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_read_value_in    (bus_read_value_in),
    .bus_ready_in         (bus_ready_in),
    .dbg_state_out        (dbg_state_out)
  );

  // ---------------- scoreboard state ----------------
  cmd_t        cmd_q[$];
  logic [31:0] iexp_q[$];
  logic [31:0] dexp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          bus_waits = 0;
  logic        stale_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by the bus responder.
  function automatic logic [31:0] bus_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  // ---------------- bus responder ----------------
  int wcnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      wcnt = 0;
      bus_ready_in = stale_ready;
      bus_read_value_in = stale_ready ? 32'h5A5A5A5A : 32'd0;
    end else if ((bus_read_out || bus_write_out) && !bus_ready_in) begin
      if (wcnt == bus_waits) begin
        bus_ready_in = 1'b1;
        bus_read_value_in = bus_data(bus_address_out);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      bus_ready_in = stale_ready;
      bus_read_value_in = stale_ready ? 32'h5A5A5A5A : 32'd0;
    end
  end

  // ---------------- monitor ----------------
  logic prev_strobe = 1'b0;
  logic prev_done = 1'b0;
  int   strobe_cycles = 0;
  cmd_t cur;
  always @(negedge clk) begin
    logic strobe;
    if (!reset_n) begin
      prev_strobe = 1'b0;
      prev_done = 1'b0;
      strobe_cycles = 0;
    end else begin
      strobe = bus_read_out | bus_write_out;
      if (prev_done)
        chk("clear_after_done", {bus_read_out, bus_write_out, bus_write_mask_out}, 32'd0);
      if (strobe && !prev_strobe) begin
        chk("cmd_expected", (cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) cur = cmd_q.pop_front();
        strobe_cycles = 0;
      end
      if (strobe) begin
        strobe_cycles++;
        chk("strobe_exclusive", bus_read_out & bus_write_out, 0);
        chk("bus_addr", bus_address_out, cur.addr);
        chk("bus_rd", bus_read_out, cur.rd);
        chk("bus_wr", bus_write_out, cur.wr);
        chk("bus_mask", bus_write_mask_out, cur.mask);
        chk("bus_wval", bus_write_value_out, cur.wval);
        if (bus_ready_in) chk("strobe_cycles", strobe_cycles, bus_waits + 1);
      end
      if (instr_ready_out) begin
        chk("instr_rdy_not_idle", strobe, 1);
        chk("instr_rdy_expected", (iexp_q.size() != 0), 1);
        if (iexp_q.size() != 0) chk("instr_value", instr_read_value_out, iexp_q.pop_front());
      end
      if (data_ready_out) begin
        chk("data_rdy_not_idle", strobe, 1);
        chk("data_rdy_expected", (dexp_q.size() != 0), 1);
        if (dexp_q.size() != 0) chk("data_value", data_read_value_out, dexp_q.pop_front());
      end
      prev_done = strobe & bus_ready_in;
      prev_strobe = strobe;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drop_all();
    instr_read_in = 1'b0;
    data_read_in  = 1'b0;
    data_write_in = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    cmd_t ci, cd;
    bit i_done, d_done;
    bit finished = 1'b0;
    bus_waits = v.waits;
    ci = '{addr: v.iaddr, rd: 1'b1, wr: 1'b0, mask: 4'd0, wval: 32'd0};
    cd = '{addr: v.daddr, rd: ~v.d_wr, wr: v.d_wr, mask: v.exp_mask, wval: v.wdata};
    if (v.data_first) begin
      if (v.use_d) cmd_q.push_back(cd);
      if (v.use_i) cmd_q.push_back(ci);
    end else begin
      if (v.use_i) cmd_q.push_back(ci);
      if (v.use_d) cmd_q.push_back(cd);
    end
    if (v.use_i) iexp_q.push_back(bus_data(v.iaddr));
    if (v.use_d) dexp_q.push_back(bus_data(v.daddr));
    @(posedge clk); #1;
    instr_read_in       = v.use_i;
    instr_address_in    = v.iaddr;
    data_read_in        = v.use_d & ~v.d_wr;
    data_write_in       = v.use_d & v.d_wr;
    data_address_in     = v.daddr;
    data_write_mask_in  = v.mask;
    data_write_value_in = v.wdata;
    i_done = ~v.use_i;
    d_done = ~v.use_d;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("strobe_before_grant", bus_read_out | bus_write_out, 0);
      if (cyc == 1) chk("strobe_after_grant", bus_read_out | bus_write_out, 1);
      if (instr_ready_out) i_done = 1'b1;
      if (data_ready_out) d_done = 1'b1;
      if (i_done && d_done) finished = 1'b1;
      else begin
        @(posedge clk); #1;
        if (i_done) instr_read_in = 1'b0;
        if (d_done) begin data_read_in = 1'b0; data_write_in = 1'b0; end
      end
    end
    chk("vec_completed", finished, 1);
    @(posedge clk); #1;
    drop_all();
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    int fn, dn;
    bit done;

    vecs[0] = '{use_i:1, iaddr:32'h100, use_d:0, d_wr:0, daddr:32'h0, wdata:32'h0,
                mask:4'h0, waits:0, exp_mask:4'h0, data_first:0};
    vecs[1] = '{use_i:0, iaddr:32'h0, use_d:1, d_wr:1, daddr:32'h2000, wdata:32'hCAFEF00D,
                mask:4'b0011, waits:3, exp_mask:4'b0011, data_first:1};
    vecs[2] = '{use_i:1, iaddr:32'h104, use_d:1, d_wr:0, daddr:32'h3000, wdata:32'h0,
                mask:4'h0, waits:1, exp_mask:4'h0, data_first:1};
    vecs[3] = '{use_i:0, iaddr:32'h0, use_d:1, d_wr:0, daddr:32'h3004, wdata:32'h0,
                mask:4'hF, waits:0, exp_mask:4'h0, data_first:1};
    vecs[4] = '{use_i:1, iaddr:32'h108, use_d:1, d_wr:1, daddr:32'h3008, wdata:$urandom,
                mask:4'h0, waits:$urandom_range(0, 2), exp_mask:4'h0, data_first:1};
    vecs[4].mask = 4'($urandom_range(1, 15));
    vecs[4].exp_mask = vecs[4].mask;
    vecs[5] = '{use_i:1, iaddr:32'h10C, use_d:0, d_wr:0, daddr:32'h0, wdata:32'h0,
                mask:4'h0, waits:2, exp_mask:4'h0, data_first:0};

    // Reset held with both requesters and the bus all active.
    reset_n = 1'b0;
    stale_ready = 1'b1;
    instr_read_in = 1'b1;
    instr_address_in = 32'h100;
    data_read_in = 1'b1;
    data_write_in = 1'b0;
    data_address_in = 32'h2000;
    data_write_mask_in = 4'hF;
    data_write_value_in = 32'h12345678;
    bus_ready_in = 1'b1;
    bus_read_value_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_bus_addr", bus_address_out, 0);
    chk("rst_bus_rd", bus_read_out, 0);
    chk("rst_bus_wr", bus_write_out, 0);
    chk("rst_bus_mask", bus_write_mask_out, 0);
    chk("rst_bus_wval", bus_write_value_out, 0);
    chk("rst_instr_rdy", instr_ready_out, 0);
    chk("rst_data_rdy", data_ready_out, 0);
    chk("rst_state", dbg_state_out, 0);
    drop_all();
    stale_ready = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Anti-starvation: fetch held continuously, loads back to back.
    bus_waits = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) cmd_q.push_back('{addr:32'h300, rd:1'b1, wr:1'b0, mask:4'd0, wval:32'd0});
      if (k == 8) cmd_q.push_back('{addr:32'h304, rd:1'b1, wr:1'b0, mask:4'd0, wval:32'd0});
      cmd_q.push_back('{addr:32'h6000 + 32'(4 * k), rd:1'b1, wr:1'b0, mask:4'd0, wval:32'd0});
      dexp_q.push_back(bus_data(32'h6000 + 32'(4 * k)));
    end
    iexp_q.push_back(bus_data(32'h300));
    iexp_q.push_back(bus_data(32'h304));
    @(posedge clk); #1;
    instr_read_in = 1'b1;
    instr_address_in = 32'h300;
    data_read_in = 1'b1;
    data_address_in = 32'h6000;
    data_write_mask_in = 4'h0;
    data_write_value_in = 32'h0;
    fn = 0; dn = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (instr_ready_out) fn++;
      if (data_ready_out) dn++;
      if (fn == 2 && dn == 9) done = 1'b1;
      else begin
        @(posedge clk); #1;
        instr_address_in = (fn >= 1) ? 32'h304 : 32'h300;
        instr_read_in = (fn < 2);
        data_address_in = 32'h6000 + 32'(4 * dn);
        data_read_in = (dn < 9);
      end
    end
    chk("starve_completed", done, 1);
    @(posedge clk); #1;
    drop_all();
    @(negedge clk);

    // Fetch redirected while the bus read to the old address is in flight.
    bus_waits = 3;
    cmd_q.push_back('{addr:32'h100, rd:1'b1, wr:1'b0, mask:4'd0, wval:32'd0});
    cmd_q.push_back('{addr:32'h400, rd:1'b1, wr:1'b0, mask:4'd0, wval:32'd0});
    iexp_q.push_back(bus_data(32'h400));
    @(posedge clk); #1;
    instr_read_in = 1'b1;
    instr_address_in = 32'h100;
    @(posedge clk);
    @(posedge clk); #1;
    instr_address_in = 32'h400;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (instr_ready_out) done = 1'b1;
    end
    chk("redirect_completed", done, 1);
    @(posedge clk); #1;
    drop_all();
    @(negedge clk);

    // Reset in the middle of a load, then a stale bus_ready_in.
    bus_waits = 10;
    cmd_q.push_back('{addr:32'h500, rd:1'b1, wr:1'b0, mask:4'd0, wval:32'd0});
    @(posedge clk); #1;
    data_read_in = 1'b1;
    data_address_in = 32'h500;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", bus_read_out, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_bus_addr", bus_address_out, 0);
    chk("midrst_bus_rd", bus_read_out, 0);
    chk("midrst_bus_wr", bus_write_out, 0);
    chk("midrst_bus_mask", bus_write_mask_out, 0);
    chk("midrst_data_rdy", data_ready_out, 0);
    chk("midrst_state", dbg_state_out, 0);
    drop_all();
    stale_ready = 1'b1;
    @(negedge clk); #2;
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      chk("stale_bus_ready", bus_ready_in, 1);
      chk("stale_data_rdy", data_ready_out, 0);
      chk("stale_instr_rdy", instr_ready_out, 0);
      chk("stale_no_strobe", bus_read_out | bus_write_out, 0);
    end
    stale_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Normal operation resumes after the aborted transaction.
    run_vec(vecs[3]);
    run_vec(vecs[0]);

    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("iexp_q_drained", iexp_q.size(), 0);
    chk("dexp_q_drained", dexp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if some wait never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish by %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/rv32_bus_arbiter.md
# rv32_bus_arbiter

Shares the single external memory bus between the instruction-fetch port and the data (load/store) port of the rv32 pipeline. It grants one requester at a time and registers the bus command. It holds the command stable until the bus signals completion, then returns the result and a one-cycle ready pulse to the granted requester. The hazard logic consumes the per-port ready signals to stall fetch and mem.

## Interface
Parameters:
- MAX_DATA_BURST, 4: maximum consecutive data grants while an instruction fetch is pending; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_address_in  in  32  fetch address.
- instr_read_in  in  1  fetch request; held until instr_ready_out.
- instr_read_value_out  out  32  fetch data; valid only while instr_ready_out=1.
- instr_ready_out  out  1  fetch complete, one-cycle pulse.
- data_address_in  in  32  load/store address.
- data_read_in  in  1  load request.
- data_write_in  in  1  store request; never asserted together with data_read_in.
- data_write_mask_in  in  4  byte enables for the store.
- data_write_value_in  in  32  store data.
- data_read_value_out  out  32  load data; valid only while data_ready_out=1.
- data_ready_out  out  1  load/store complete, one-cycle pulse.
- bus_address_out  out  32  registered bus address.
- bus_read_out  out  1  registered bus read strobe.
- bus_write_out  out  1  registered bus write strobe.
- bus_write_mask_out  out  4  registered byte enables; 0 for reads.
- bus_write_value_out  out  32  registered store data.
- bus_read_value_in  in  32  bus read data, valid with bus_ready_in.
- bus_ready_in  in  1  bus transaction complete.

## Operation
- FSM states: IDLE, INSTR_BUSY, DATA_BUSY.
- **IDLE arbitration.**
  - Data wins if data_read_in or data_write_in is asserted.
  - Exception: when instr_read_in=1 and streak==MAX_DATA_BURST, instruction wins.
  - Otherwise instruction wins if instr_read_in=1.
  - With no request, stay in IDLE.
- **On grant.**
  - Register the winner's address, strobes, mask and write value into the bus_* outputs.
  - For an instruction grant, bus_read_out=1 and mask/value=0.
  - Move to INSTR_BUSY or DATA_BUSY.
  - Latch the granted address and kind (read/write) internally for the match check.
- **BUSY.**
  - Bus outputs are held unchanged until bus_ready_in=1.
  - In the bus_ready_in cycle: clear bus_read_out, bus_write_out and bus_write_mask_out at the next edge, and return to IDLE.
  - Re-arbitration never happens in the completion cycle.
- **Ready pulse.**
  - instr_ready_out = (state==INSTR_BUSY) && bus_ready_in && instr_read_in && instr_address_in==latched address.
  - data_ready_out is the same, with DATA_BUSY and a matching address and kind.
  - *_read_value_out = bus_read_value_in, passed combinationally, with no register.
- **Abandoned request.** If the requester dropped or changed its request (e.g. fetch redirected by a taken branch), the bus transaction still completes. The ready pulse is suppressed, the result is discarded, and the new request is arbitrated from IDLE.
- **Streak counter.** 4 bits, saturating at MAX_DATA_BURST.
  - +1 on each data grant made while instr_read_in=1.
  - Cleared on any instruction grant.
  - Cleared in any IDLE cycle with instr_read_in=0.

## Timing
- **Reset.** reset_n low forces, immediately:
  - state=IDLE, streak=0;
  - all bus_* outputs 0;
  - instr_ready_out=0 and data_ready_out=0.
- Reset asserted mid-transaction aborts it. After release, the arbiter ignores any bus_ready_in until it issues a new grant.
- **Latency.** Request seen in IDLE at cycle N → bus strobe at N+1. bus_ready_in at cycle M≥N+1 → ready pulse at M → IDLE at M+1 → next strobe at M+2 at the earliest.
- **Throughput.** Zero-wait bus gives 1 transaction per 2 cycles.
- Ready outputs are never asserted in IDLE and never for more than one cycle per grant.
- bus_read_out and bus_write_out are never both 1.
- Both requests arriving in the same IDLE cycle follow the arbitration rule; the loser stays pending with no timeout.

## Test plan
- **Reset.** Hold reset_n=0 with both requests active → all outputs 0. Release, then instr_read_in=1 at 0x100 → bus_read_out=1, bus_address_out=0x100 one cycle later. Return bus_ready_in with value 0xDEADBEEF → instr_ready_out pulses 1 cycle with 0xDEADBEEF.
- **Store wait states.** Store 0xCAFEF00D, mask 0b0011, to 0x2000 with 3 wait states → bus outputs stable for 4 cycles. data_ready_out pulses once; bus_write_out and bus_write_mask_out are 0 the next cycle.
- **Simultaneous requests.** Fetch and load arrive together → load granted first. Fetch granted on the next IDLE; both complete with the correct values.
- **Anti-starvation.** Fetch continuously pending, data requesting back-to-back, MAX_DATA_BURST=4 → exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- **Redirect during fetch.** Fetch address changes 0x100→0x400 mid-transaction → no instr_ready_out for 0x100. Next bus read is issued to 0x400.
- **Mid-transaction reset.** Assert reset_n low during DATA_BUSY → outputs 0 immediately. A stale bus_ready_in after release produces no ready pulse.
